// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and the divider helper.
package uart_pkg;

  localparam int OS_FACTOR  = 8;
  localparam int MID_SAMPLE = 3;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // clk cycles per oversample tick, floored and clamped so the tick counter always runs.
  function automatic int os_div(input int freq, input int baud);
    int d;
    d = freq / (baud * OS_FACTOR);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample enable generator: one-clk os_tick every OS_DIV cycles, realignable via clear.
module uart_os_tick #(
  parameter int OS_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic os_tick
);

  localparam int            CW   = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

  logic [CW-1:0] cnt;

  // NOTE: sequential state is written with <= so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A tick in the realignment cycle would land on the wrong boundary, so it is dropped.
  assign os_tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_rx_os8.sv
// 8N1 UART receiver, 8x oversampling, valid/ready byte output with frame and overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd) and the parity_err output.
module uart_rx_os8
  import uart_pkg::*;
#(
  parameter int BAUD_RATE = 115200,
  parameter int FREQUENCY = 100000000
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int OS_DIV = os_div(FREQUENCY, BAUD_RATE);

  rx_state_t state, state_next;

  logic                 rxd_meta, rxd_sync, rxd_prev;
  logic                 start_edge;
  logic                 os_tick;
  logic [2:0]           os_cnt;
  logic                 mid_sample;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 accept;

  logic start_det, shift_en, load_byte, overrun_evt, frame_evt;
`ifdef UART_RX_PARITY_EN
  logic parity_bit, par_en, parity_bad, parity_evt;
`endif

  // Two flops resolve metastability; the third gives the previous level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  assign start_edge = rxd_prev & ~rxd_sync;
  assign mid_sample = os_tick && (os_cnt == 3'(MID_SAMPLE));
  assign accept     = rx_valid & rx_ready;
  assign busy       = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  assign parity_bad = ((^shift_reg) ^ parity_bit) != PARITY_ODD;
`endif

  uart_os_tick #(
    .OS_DIV(OS_DIV)
  ) u_os_tick (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_det),
    .os_tick(os_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next  = state;
    start_det   = 1'b0;
    shift_en    = 1'b0;
    load_byte   = 1'b0;
    overrun_evt = 1'b0;
    frame_evt   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en      = 1'b0;
    parity_evt  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_edge) begin
          start_det  = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (mid_sample) begin
          state_next = rxd_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (mid_sample) begin
          shift_en = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (mid_sample) begin
          par_en     = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (mid_sample) begin
          if (!rxd_sync) begin
            frame_evt  = 1'b1;
            state_next = WAIT_HIGH;
          end else begin
            state_next = IDLE;
            // A byte being accepted this very cycle frees the output register for the new one.
`ifdef UART_RX_PARITY_EN
            if (parity_bad) begin
              parity_evt = 1'b1;
            end else if (!rx_valid || rx_ready) begin
              load_byte = 1'b1;
            end else begin
              overrun_evt = 1'b1;
            end
`else
            if (!rx_valid || rx_ready) begin
              load_byte = 1'b1;
            end else begin
              overrun_evt = 1'b1;
            end
`endif
          end
        end
      end
      WAIT_HIGH: begin
        if (rxd_sync) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt      <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit  <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_err   <= frame_evt;
      overrun_err <= overrun_evt;
`ifdef UART_RX_PARITY_EN
      parity_err  <= parity_evt;
      if (par_en) begin
        parity_bit <= rxd_sync;
      end
`endif
      // os_cnt restarts at the start edge so count 3 lands mid-bit; it wraps freely afterwards.
      if (start_det) begin
        os_cnt <= '0;
      end else if (os_tick) begin
        os_cnt <= os_cnt + 3'd1;
      end

      if (start_det) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end

      if (shift_en) begin
        shift_reg <= {rxd_sync, shift_reg[DATA_BITS-1:1]};
      end

      if (load_byte) begin
        rx_data  <= shift_reg;
        rx_valid <= 1'b1;
      end else if (accept) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
